branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4: in-flight branch queue entries (power of 2, >=2).
REQ-002 Parameter PC_W, default 9: fetch PC width.
REQ-003 Parameter IDX_BITS, default 6: BHT index width (64 entries); index = pc[IDX_BITS-1:0].
REQ-004 Parameter CNT_W, default 16: statistics counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pred_valid  input  1  fetch issues a predicted branch.
REQ-008 pred_ready  output  1  queue can accept; equals !full.
REQ-009 pred_pc  input  PC_W  PC of the predicted branch.
REQ-010 pred_taken  input  1  prediction made at fetch.
REQ-011 res_valid  input  1  execute resolves the oldest in-flight branch.
REQ-012 res_taken  input  1  actual outcome.
REQ-013 res_ready  output  1  resolution accepted; equals !empty && (!upd_valid || upd_ready).
REQ-014 upd_valid  output  1  BHT training request pending.
REQ-015 upd_ready  input  1  BHT accepts training request.
REQ-016 upd_index  output  IDX_BITS  BHT entry to train.
REQ-017 upd_taken  output  1  outcome to train with.
REQ-018 mispredict  output  1  one-cycle flush pulse to fetch.
REQ-019 hit_count, miss_count  output  CNT_W each  saturating prediction statistics.

Function
REQ-020 Enqueue SHALL occur when pred_valid && pred_ready; pred_ready uses the pre-edge full state (a simultaneous pop does not unblock a full queue).
REQ-021 Resolve SHALL occur when res_valid && res_ready; res_valid with empty queue SHALL be ignored with no state change.
REQ-022 On resolve the head entry SHALL be popped and the update register loaded: upd_index = head_pc[IDX_BITS-1:0], upd_taken = res_taken, upd_valid = 1 from the next cycle (latency 1).
REQ-023 upd_valid SHALL hold with stable upd_index/upd_taken until upd_valid && upd_ready; it then clears unless a new resolve loads it in the same cycle (back-to-back throughput 1/cycle).
REQ-024 Correct prediction (res_taken == head_taken): hit_count += 1, queue otherwise unchanged.
REQ-025 Misprediction: mispredict SHALL pulse high for exactly the next cycle, miss_count += 1, and the whole queue SHALL be emptied at the same edge (younger entries are wrong-path).
REQ-026 An enqueue coinciding with a mispredicting resolve SHALL be discarded; an enqueue coinciding with a correct resolve SHALL be kept (count unchanged net).
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 Queue pointers SHALL wrap modulo DEPTH; occupancy tracked with a count of width $clog2(DEPTH)+1.
REQ-029 Queue order SHALL be strict FIFO; resolutions always apply to the oldest entry.

Reset
REQ-030 Assertion of reset (low), at any time, SHALL immediately empty the queue, drop any pending update, and clear both counters.
REQ-031 Output values during/after reset: pred_ready=1, res_ready=0, upd_valid=0, upd_index=0, upd_taken=0, mispredict=0, hit_count=0, miss_count=0.
REQ-032 First enqueue SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Constants PC_W, IDX_BITS, DEPTH defaults and the queue entry layout {pc, predicted} SHALL live in shared package bp_pkg, also used by the BHT.
REQ-034 The in-flight queue SHALL be sub-module bp_fifo (push, pop, flush, full, empty, head); counters, update register and mispredict logic stay in branch_resolve_unit.

Verification
REQ-035 Enqueue pc=0x045 taken=1, resolve res_taken=1 -> next cycle upd_valid=1, upd_index=0x05, upd_taken=1, mispredict=0, hit_count=1.
REQ-036 Enqueue pc=0x1C3 (pred 0), 0x010, 0x011; resolve taken=1 -> mispredict pulse 1 cycle, miss_count=1, queue empty, res_ready=0, upd_index=0x03.
REQ-037 Fill 4 entries -> pred_ready=0; push+correct pop same cycle -> push rejected, occupancy 3.
REQ-038 Hold upd_ready=0 for 3 cycles after a resolve -> upd_valid/index stable, res_ready=0; upd_ready=1 -> accepted, next resolve accepted.
REQ-039 Preload counters at 0xFFFE, two correct resolves -> hit_count=0xFFFF, stays 0xFFFF.
REQ-040 Assert reset mid-stream with 3 entries and upd_valid=1 -> all outputs to REQ-031 values asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor shared definitions: default geometry and the
// in-flight queue entry layout, shared by the resolve unit and the BHT.
package bp_pkg;

    localparam int BP_PC_W     = 9;
    localparam int BP_IDX_BITS = 6;
    localparam int BP_DEPTH    = 4;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               predicted;
    } bp_entry_t;

    function automatic logic is_mispredict(input logic predicted,
                                           input logic actual);
        return predicted != actual;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// In-flight branch queue: strict FIFO with a single-cycle flush that
// discards every entry, including one being pushed in the same cycle.
module bp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: tracks in-flight predictions, trains the BHT,
// flushes fetch on a mispredict and keeps saturating hit/miss stats.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH    = BP_DEPTH,
    parameter int PC_W     = BP_PC_W,
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pred_valid,
    output logic                pred_ready,
    input  logic [PC_W-1:0]     pred_pc,
    input  logic                pred_taken,
    input  logic                res_valid,
    input  logic                res_taken,
    output logic                res_ready,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [IDX_BITS-1:0] upd_index,
    output logic                upd_taken,
    output logic                mispredict,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            full;
    logic            empty;
    logic [PC_W:0]   head;
    logic [PC_W-1:0] head_pc;
    logic            head_taken;
    logic            resolve;
    logic            miss;
    logic            push;
    logic            unused_pc_hi;

    assign head_pc      = head[PC_W:1];
    assign head_taken   = head[0];
    assign unused_pc_hi = ^head_pc[PC_W-1:IDX_BITS];

    assign pred_ready = !full;
    assign res_ready  = !empty && (!upd_valid || upd_ready);
    assign resolve    = res_valid && res_ready;
    assign miss       = resolve && is_mispredict(head_taken, res_taken);
    // A push in the flush cycle is wrong-path and must not survive it.
    assign push       = pred_valid && pred_ready && !miss;

    bp_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (resolve),
        .flush (miss),
        .din   ({pred_pc, pred_taken}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid <= 1'b0;
            upd_index <= '0;
            upd_taken <= 1'b0;
        end else if (resolve) begin
            upd_valid <= 1'b1;
            upd_index <= head_pc[IDX_BITS-1:0];
            upd_taken <= res_taken;
        end else if (upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            mispredict <= miss;
            if (resolve && !miss && hit_count != CNT_MAX) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss && miss_count != CNT_MAX) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, scoreboard
// of expected BHT updates, and directed multi-cycle sequences.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic        pred_ready;
    logic [8:0]  pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        res_ready;
    logic        upd_valid;
    logic        upd_ready;
    logic [5:0]  upd_index;
    logic        upd_taken;
    logic        mispredict;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    // Narrow-counter instance to reach saturation quickly.
    logic        s_pred_valid;
    logic        s_pred_ready;
    logic [8:0]  s_pred_pc;
    logic        s_pred_taken;
    logic        s_res_valid;
    logic        s_res_taken;
    logic        s_res_ready;
    logic        s_upd_valid;
    logic [5:0]  s_upd_index;
    logic        s_upd_taken;
    logic        s_mispredict;
    logic [1:0]  s_hit;
    logic [1:0]  s_miss;

    int tests;
    int fails;
    int exp_hit;
    int exp_miss;

    typedef struct {
        logic [8:0] pc;
        logic       pred;
        logic       res;
        logic [5:0] idx;
        logic       mis;
    } vec_t;

    typedef struct {
        logic [5:0] idx;
        logic       taken;
        logic       mis;
    } exp_t;

    vec_t vecs [5];
    exp_t sb [$];

    branch_resolve_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_ready (pred_ready),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    branch_resolve_unit #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (s_pred_valid),
        .pred_ready (s_pred_ready),
        .pred_pc    (s_pred_pc),
        .pred_taken (s_pred_taken),
        .res_valid  (s_res_valid),
        .res_taken  (s_res_taken),
        .res_ready  (s_res_ready),
        .upd_valid  (s_upd_valid),
        .upd_ready  (1'b1),
        .upd_index  (s_upd_index),
        .upd_taken  (s_upd_taken),
        .mispredict (s_mispredict),
        .hit_count  (s_hit),
        .miss_count (s_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [5:0] idx, input logic tk,
                              input logic mis);
        exp_t e;
        e.idx   = idx;
        e.taken = tk;
        e.mis   = mis;
        sb.push_back(e);
        if (mis) exp_miss++;
        else exp_hit++;
    endtask

    task automatic check_upd(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, 32'(upd_valid), 32'd1);
            chk({name, "_index"}, 32'(upd_index), 32'(e.idx));
            chk({name, "_taken"}, 32'(upd_taken), 32'(e.taken));
            chk({name, "_mispred"}, 32'(mispredict), 32'(e.mis));
        end
    endtask

    task automatic push1(input logic [8:0] pc, input logic pt);
        pred_valid = 1'b1;
        pred_pc    = pc;
        pred_taken = pt;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_hit"}, 32'(hit_count), 32'(exp_hit));
        chk({name, "_miss"}, 32'(miss_count), 32'(exp_miss));
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_pred_ready"}, 32'(pred_ready), 32'd1);
        chk({name, "_res_ready"}, 32'(res_ready), 32'd0);
        chk({name, "_upd_valid"}, 32'(upd_valid), 32'd0);
        chk({name, "_upd_index"}, 32'(upd_index), 32'd0);
        chk({name, "_upd_taken"}, 32'(upd_taken), 32'd0);
        chk({name, "_mispred"}, 32'(mispredict), 32'd0);
        chk({name, "_hit"}, 32'(hit_count), 32'd0);
        chk({name, "_miss"}, 32'(miss_count), 32'd0);
    endtask

    initial begin
        vecs[0] = '{pc: 9'h045, pred: 1'b1, res: 1'b1, idx: 6'h05, mis: 1'b0};
        vecs[1] = '{pc: 9'h1C3, pred: 1'b0, res: 1'b1, idx: 6'h03, mis: 1'b1};
        vecs[2] = '{pc: 9'h0FF, pred: 1'b1, res: 1'b0, idx: 6'h3F, mis: 1'b1};
        vecs[3] = '{pc: 9'h140, pred: 1'b0, res: 1'b0, idx: 6'h00, mis: 1'b0};
        vecs[4] = '{pc: 9'h1AA, pred: 1'b1, res: 1'b1, idx: 6'h2A, mis: 1'b0};

        tests = 0;
        fails = 0;
        exp_hit = 0;
        exp_miss = 0;
        pred_valid = 0; pred_pc = '0; pred_taken = 0;
        res_valid = 0; res_taken = 0; upd_ready = 1;
        s_pred_valid = 0; s_pred_pc = '0; s_pred_taken = 0;
        s_res_valid = 0; s_res_taken = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 chk_reset_outs("rst");
        tick();
        tick();
        reset = 1'b1;

        // Vector table: one push, one resolve, then the update follows.
        for (int i = 0; i < 5; i++) begin
            push1(vecs[i].pc, vecs[i].pred);
            chk($sformatf("v%0d_res_ready", i), 32'(res_ready), 32'd1);
            res_valid = 1'b1;
            res_taken = vecs[i].res;
            expect_upd(vecs[i].idx, vecs[i].res, vecs[i].mis);
            tick();
            res_valid = 1'b0;
            check_upd($sformatf("v%0d", i));
            chk_counts($sformatf("v%0d", i));
            chk($sformatf("v%0d_empty", i), 32'(res_ready), 32'd0);
            tick();
            chk($sformatf("v%0d_pulse", i), 32'(mispredict), 32'd0);
            chk($sformatf("v%0d_upd_clr", i), 32'(upd_valid), 32'd0);
        end

        // Mispredict with younger wrong-path entries flushes them all.
        push1(9'h1C3, 1'b0);
        push1(9'h010, 1'b1);
        push1(9'h011, 1'b1);
        res_valid = 1'b1;
        res_taken = 1'b1;
        expect_upd(6'h03, 1'b1, 1'b1);
        tick();
        res_valid = 1'b0;
        check_upd("flush");
        chk("flush_empty", 32'(res_ready), 32'd0);
        chk_counts("flush");
        tick();
        chk("flush_pulse", 32'(mispredict), 32'd0);
        chk("flush_pred_ready", 32'(pred_ready), 32'd1);

        // Full queue: simultaneous pop does not admit a push.
        push1(9'h020, 1'b1);
        push1(9'h021, 1'b1);
        push1(9'h022, 1'b1);
        push1(9'h023, 1'b1);
        chk("full_pred_ready", 32'(pred_ready), 32'd0);
        pred_valid = 1'b1;
        pred_pc    = 9'h030;
        pred_taken = 1'b1;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        expect_upd(6'h20, 1'b1, 1'b0);
        tick();
        pred_valid = 1'b0;
        check_upd("full_pop0");
        chk("full_occ3", 32'(pred_ready), 32'd1);
        for (int k = 1; k < 4; k++) begin
            expect_upd(6'(6'h20 + k), 1'b1, 1'b0);
            tick();
            check_upd($sformatf("full_pop%0d", k));
        end
        res_valid = 1'b0;
        chk("full_dropped", 32'(res_ready), 32'd0);
        chk_counts("full");

        // Push with a correct resolve survives.
        push1(9'h050, 1'b1);
        pred_valid = 1'b1;
        pred_pc    = 9'h051;
        pred_taken = 1'b0;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        expect_upd(6'h10, 1'b1, 1'b0);
        tick();
        pred_valid = 1'b0;
        check_upd("keep0");
        chk("keep_kept", 32'(res_ready), 32'd1);
        res_taken = 1'b0;
        expect_upd(6'h11, 1'b0, 1'b0);
        tick();
        res_valid = 1'b0;
        check_upd("keep1");
        chk("keep_empty", 32'(res_ready), 32'd0);

        // Push with a mispredicting resolve is discarded.
        push1(9'h060, 1'b1);
        pred_valid = 1'b1;
        pred_pc    = 9'h061;
        pred_taken = 1'b1;
        res_valid  = 1'b1;
        res_taken  = 1'b0;
        expect_upd(6'h20, 1'b0, 1'b1);
        tick();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        check_upd("drop");
        chk("drop_empty", 32'(res_ready), 32'd0);
        tick();
        chk("drop_pulse", 32'(mispredict), 32'd0);
        chk_counts("drop");

        // Update backpressure holds the register and blocks resolves.
        push1(9'h077, 1'b1);
        push1(9'h078, 1'b1);
        upd_ready = 1'b0;
        res_valid = 1'b1;
        res_taken = 1'b1;
        expect_upd(6'h37, 1'b1, 1'b0);
        tick();
        check_upd("bp0");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", k), 32'(upd_valid), 32'd1);
            chk($sformatf("bp_hold%0d_index", k), 32'(upd_index), 32'h37);
            chk($sformatf("bp_hold%0d_res_rdy", k), 32'(res_ready), 32'd0);
        end
        upd_ready = 1'b1;
        #1 chk("bp_release", 32'(res_ready), 32'd1);
        expect_upd(6'h38, 1'b1, 1'b0);
        tick();
        res_valid = 1'b0;
        check_upd("bp1");
        chk_counts("bp");

        // Saturation on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            s_pred_valid = 1'b1;
            s_pred_pc    = 9'(k);
            s_pred_taken = 1'b1;
            tick();
            s_pred_valid = 1'b0;
            s_res_valid  = 1'b1;
            s_res_taken  = 1'b1;
            tick();
            s_res_valid  = 1'b0;
            chk($sformatf("sat_hit%0d", k), 32'(s_hit), (k < 3) ? k + 1 : 3);
        end
        for (int k = 0; k < 4; k++) begin
            s_pred_valid = 1'b1;
            s_pred_pc    = 9'(k);
            s_pred_taken = 1'b0;
            tick();
            s_pred_valid = 1'b0;
            s_res_valid  = 1'b1;
            s_res_taken  = 1'b1;
            tick();
            s_res_valid  = 1'b0;
            chk($sformatf("sat_miss%0d", k), 32'(s_miss), (k < 3) ? k + 1 : 3);
        end
        chk("sat_hit_hold", 32'(s_hit), 32'd3);

        // Asynchronous reset mid-stream.
        push1(9'h105, 1'b1);
        push1(9'h106, 1'b1);
        push1(9'h107, 1'b1);
        push1(9'h108, 1'b1);
        upd_ready = 1'b0;
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("pre_rst_upd", 32'(upd_valid), 32'd1);
        #3 reset = 1'b0;
        #1 chk_reset_outs("arst");
        tick();
        chk_reset_outs("arst_hold");
        reset = 1'b1;
        upd_ready = 1'b1;
        tick();
        chk("post_rst_res_ready", 32'(res_ready), 32'd0);
        chk("post_rst_pred_ready", 32'(pred_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
